exmem_pipe: RTL and testbench
=============================

Name: exmem_pipe

Overview:
- EX/MEM pipeline register for the 5-stage MIPS datapath; sits directly downstream of the execute stage, which is fed by the ID/EX latch.
- Latches execute results and control.
- Owns the data-memory request handshake: drives dmemREN/dmemWEN until dhit, captures load data, and stalls the pipeline while the access is outstanding.
- Exports a stall-cycle counter for performance measurement.

Parameters:
STALL_CNT_W, 32, width of the saturating memory-stall cycle counter.

Ports:
CLK  input  1  system clock, rising edge.
nRST  input  1  synchronous active-low reset.
en  input  1  hazard-unit enable; 0 holds all latched state.
flush  input  1  load a bubble instead of EX values.
ex_RegWEN  input  1  register write enable from EX.
ex_MemtoReg  input  memtoreg_t  writeback source select.
ex_dWENi  input  1  store request.
ex_dRENi  input  1  load request.
ex_halt  input  1  halt instruction in EX.
ex_wsel  input  5  destination register (regbits_t).
ex_aluout  input  32  ALU result / memory address.
ex_storedata  input  32  forwarded rt value for stores.
ex_npc  input  32  PC+4 for JAL writeback.
dhit  input  1  data cache/memory access complete.
dmemload  input  32  load data, valid when dhit.
dmemREN  output  1  data read request.
dmemWEN  output  1  data write request.
dmemaddr  output  32  = mem_aluout.
dmemstore  output  32  = latched storedata.
mem_stall  output  1  access outstanding; upstream must hold.
mem_RegWEN, mem_MemtoReg, mem_wsel, mem_aluout, mem_npc  output  as inputs  latched values to MEM/WB.
mem_loaddata  output  32  captured dmemload.
mem_halt  output  1  sticky halt.
mem_valid  output  1  slot holds a real instruction.
stall_cycles  output  STALL_CNT_W  count of cycles with mem_stall=1.

Behaviour:
- One clock; all state updates on the rising edge of CLK. Reset is synchronous, active-low: nRST=0 at an edge clears state.
- Reset values: all outputs 0, FSM in IDLE, stall_cycles 0. A reset mid-access drops the request the next cycle, with no dhit required.
- FSM states:
  - IDLE: no outstanding access.
  - ACCESS: request pending.
  - FROZEN: halt latched.
- Load condition: load = en & ~mem_stall & ~mem_halt.
  - flush=1 with load: bubble. RegWEN, dWEN, dREN, halt and valid are cleared; data fields are don't-care (drive 0).
  - flush=1 without load: has no effect.
  - flush and en both 1: flush wins.
- Transitions:
  - IDLE -> ACCESS when load loads an instruction with ex_dRENi | ex_dWENi.
  - ACCESS -> IDLE on dhit.
  - Any state -> FROZEN when a halt instruction is loaded.
  - FROZEN is left only via reset.
- Request outputs: dmemREN = (state==ACCESS) & latched dRENi; dmemWEN likewise. Both are deasserted the cycle after dhit.
- Stall: mem_stall = (state==ACCESS) & ~dhit, combinational. A zero-wait dhit in the first ACCESS cycle gives no stall; the next instruction loads on the same edge.
- Load capture: on dhit for a load, mem_loaddata <= dmemload. Otherwise mem_loaddata holds.
- Latch hold: en=0 or mem_stall=1 holds every latched field unchanged.
- Halt: the halt instruction's own fields latch normally and mem_halt=1. No further loads occur; mem_halt stays 1.
  - Halt never shares a slot with a memory op, so an ACCESS in progress is never abandoned.
- stall_cycles: increments each cycle mem_stall=1; saturates at all-ones, with no wrap.
- dREN and dWEN both set on one instruction is illegal; the bench must assert on it, and the RTL gives dWEN priority.

Decomposition:
- Use existing cpu_types_pkg (word_t, regbits_t) and control_unit_types_pkg (memtoreg_t).
- Add to control_unit_types_pkg: exmem_state_t enum {IDLE, ACCESS, FROZEN}.
- Add an exmempipe_if interface (ex/mem modports) mirroring the ID/EX interface style.
- One natural sub-module: exmem_memctl, holding the FSM, request outputs, mem_stall and the stall counter. The top holds the data latches.

Test Plan:
- Reset and hold: hold nRST=0 two cycles with ex_RegWEN=1 -> all outputs 0, stall_cycles=0. Release with en=0 -> outputs remain 0.
- ALU passthrough: en=1, aluout=0x0000_1234, wsel=5, RegWEN=1 -> next cycle mem_aluout=0x1234, mem_wsel=5, mem_valid=1, dmemREN=dmemWEN=0, mem_stall=0.
- Load with 3-cycle latency: dRENi=1, aluout=0x100; dhit on the 3rd ACCESS cycle, dmemload=0xDEADBEEF ->
  - dmemREN=1 and dmemaddr=0x100 for 3 cycles; mem_stall=1 for 2 cycles.
  - mem_loaddata=0xDEADBEEF; stall_cycles=2; dmemREN=0 the next cycle.
- Zero-wait store: dWENi=1, storedata=0xCAFE, dhit in the first cycle -> dmemWEN pulse of 1 cycle, mem_stall never 1, next instruction latched on the following edge.
- Flush and stall interaction: flush=1 with en=1 -> mem_valid=0, RegWEN=0. flush=1 asserted during a pending load -> no change until dhit.
- Halt freeze: halt latched -> mem_halt=1. Later inputs with en=1 do not change any output over 10 cycles. nRST=0 clears mem_halt.

Source files
------------

// File: rtl/control_unit_types_pkg.sv
// Control-path types: writeback source select and EX/MEM memory FSM states.
package control_unit_types_pkg;
  typedef enum logic [1:0] {
    MTR_ALU = 2'd0,
    MTR_MEM = 2'd1,
    MTR_NPC = 2'd2
  } memtoreg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FROZEN = 2'd2
  } exmem_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the 5-stage MIPS core.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
endpackage

// File: rtl/exmempipe_if.sv
// EX -> EX/MEM latch bundle; ex modport is the execute stage, mem modport the latch.
interface exmempipe_if;
  import cpu_types_pkg::*;
  import control_unit_types_pkg::*;

  logic      ex_RegWEN, ex_dWENi, ex_dRENi, ex_halt;
  memtoreg_t ex_MemtoReg;
  regbits_t  ex_wsel;
  word_t     ex_aluout, ex_storedata, ex_npc;

  logic      mem_RegWEN, mem_halt, mem_valid;
  memtoreg_t mem_MemtoReg;
  regbits_t  mem_wsel;
  word_t     mem_aluout, mem_npc, mem_loaddata;

  modport ex (
    output ex_RegWEN, ex_MemtoReg, ex_dWENi, ex_dRENi, ex_halt,
           ex_wsel, ex_aluout, ex_storedata, ex_npc,
    input  mem_RegWEN, mem_MemtoReg, mem_wsel, mem_aluout, mem_npc,
           mem_loaddata, mem_halt, mem_valid
  );

  modport mem (
    input  ex_RegWEN, ex_MemtoReg, ex_dWENi, ex_dRENi, ex_halt,
           ex_wsel, ex_aluout, ex_storedata, ex_npc,
    output mem_RegWEN, mem_MemtoReg, mem_wsel, mem_aluout, mem_npc,
           mem_loaddata, mem_halt, mem_valid
  );
endinterface

// File: rtl/exmem_memctl.sv
// Data-memory handshake FSM for the EX/MEM slot: request outputs, stall, stall counter.
module exmem_memctl
  import control_unit_types_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   mem_halt,
  input  logic                   ex_dRENi,
  input  logic                   ex_dWENi,
  input  logic                   ex_halt,
  input  logic                   dhit,
  output logic                   load,
  output logic                   mem_stall,
  output logic                   dmemREN,
  output logic                   dmemWEN,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  exmem_state_t           state_q, state_d;
  logic                   dren_q, dren_d, dwen_q, dwen_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   take, mem_op;

  always_comb begin
    mem_stall = (state_q == ACCESS) & ~dhit;
    load      = en & ~mem_stall & ~mem_halt;
    take      = load & ~flush;
    mem_op    = ex_dRENi | ex_dWENi;
    state_d   = state_q;
    dren_d    = dren_q;
    dwen_d    = dwen_q;
    cnt_d     = cnt_q;

    // Store wins if both request bits arrive together.
    if (load) begin
      dwen_d = take & ex_dWENi;
      dren_d = take & ex_dRENi & ~ex_dWENi;
    end

    case (state_q)
      IDLE:    if (take && mem_op) state_d = ACCESS;
      ACCESS:  if (dhit) state_d = (take && mem_op) ? ACCESS : IDLE;
      FROZEN:  state_d = FROZEN;
      default: state_d = IDLE;
    endcase
    if (take && ex_halt) state_d = FROZEN;

    if (mem_stall && (cnt_q != '1)) cnt_d = cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      dren_q  <= 1'b0;
      dwen_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dren_q  <= dren_d;
      dwen_q  <= dwen_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmemREN      = (state_q == ACCESS) & dren_q;
  assign dmemWEN      = (state_q == ACCESS) & dwen_q;
  assign stall_cycles = cnt_q;
endmodule

// File: rtl/exmem_pipe.sv
// EX/MEM pipeline register: latches execute results and control, delegates the memory handshake.
module exmem_pipe
  import cpu_types_pkg::*;
  import control_unit_types_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   dhit,
  input  word_t                  dmemload,
  output logic                   dmemREN,
  output logic                   dmemWEN,
  output word_t                  dmemaddr,
  output word_t                  dmemstore,
  output logic                   mem_stall,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  exmempipe_if.mem               epif
);
  logic      load;
  logic      regwen_q, regwen_d, halt_q, halt_d, valid_q, valid_d;
  memtoreg_t memtoreg_q, memtoreg_d;
  regbits_t  wsel_q, wsel_d;
  word_t     aluout_q, aluout_d, storedata_q, storedata_d;
  word_t     npc_q, npc_d, loaddata_q, loaddata_d;

  exmem_memctl #(.STALL_CNT_W(STALL_CNT_W)) u_memctl (
    .CLK          (CLK),
    .nRST         (nRST),
    .en           (en),
    .flush        (flush),
    .mem_halt     (halt_q),
    .ex_dRENi     (epif.ex_dRENi),
    .ex_dWENi     (epif.ex_dWENi),
    .ex_halt      (epif.ex_halt),
    .dhit         (dhit),
    .load         (load),
    .mem_stall    (mem_stall),
    .dmemREN      (dmemREN),
    .dmemWEN      (dmemWEN),
    .stall_cycles (stall_cycles)
  );

  always_comb begin
    regwen_d    = regwen_q;
    memtoreg_d  = memtoreg_q;
    halt_d      = halt_q;
    valid_d     = valid_q;
    wsel_d      = wsel_q;
    aluout_d    = aluout_q;
    storedata_d = storedata_q;
    npc_d       = npc_q;
    loaddata_d  = loaddata_q;

    if (load) begin
      if (flush) begin
        regwen_d    = 1'b0;
        memtoreg_d  = MTR_ALU;
        halt_d      = 1'b0;
        valid_d     = 1'b0;
        wsel_d      = '0;
        aluout_d    = '0;
        storedata_d = '0;
        npc_d       = '0;
      end else begin
        regwen_d    = epif.ex_RegWEN;
        memtoreg_d  = epif.ex_MemtoReg;
        halt_d      = epif.ex_halt;
        valid_d     = 1'b1;
        wsel_d      = epif.ex_wsel;
        aluout_d    = epif.ex_aluout;
        storedata_d = epif.ex_storedata;
        npc_d       = epif.ex_npc;
      end
    end

    // dmemREN is only high while the load is outstanding, so this captures exactly once.
    if (dhit && dmemREN) loaddata_d = dmemload;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      regwen_q    <= 1'b0;
      memtoreg_q  <= MTR_ALU;
      halt_q      <= 1'b0;
      valid_q     <= 1'b0;
      wsel_q      <= '0;
      aluout_q    <= '0;
      storedata_q <= '0;
      npc_q       <= '0;
      loaddata_q  <= '0;
    end else begin
      regwen_q    <= regwen_d;
      memtoreg_q  <= memtoreg_d;
      halt_q      <= halt_d;
      valid_q     <= valid_d;
      wsel_q      <= wsel_d;
      aluout_q    <= aluout_d;
      storedata_q <= storedata_d;
      npc_q       <= npc_d;
      loaddata_q  <= loaddata_d;
    end
  end

  assign dmemaddr          = aluout_q;
  assign dmemstore         = storedata_q;
  assign epif.mem_RegWEN   = regwen_q;
  assign epif.mem_MemtoReg = memtoreg_q;
  assign epif.mem_halt     = halt_q;
  assign epif.mem_valid    = valid_q;
  assign epif.mem_wsel     = wsel_q;
  assign epif.mem_aluout   = aluout_q;
  assign epif.mem_npc      = npc_q;
  assign epif.mem_loaddata = loaddata_q;
endmodule

// File: tb/tb_exmem_pipe.sv
// Directed bench for exmem_pipe: vector table for plain latching, hand sequences for memory/halt.
module tb_exmem_pipe;
  import control_unit_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST, en, flush, dhit;
  logic [31:0] dmemload, dmemaddr, dmemstore;
  logic        dmemREN, dmemWEN, mem_stall;
  logic [31:0] stall_cycles;
  int          checks = 0;
  int          failures = 0;

  exmempipe_if epif();

  exmem_pipe #(.STALL_CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .dhit(dhit),
    .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
    .stall_cycles(stall_cycles), .epif(epif)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (nRST && en)
      assert (!(epif.ex_dRENi && epif.ex_dWENi)) else $error("illegal: dREN and dWEN both set");

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        en, flush, regwen;
    logic [1:0]  mtr;
    logic [4:0]  wsel;
    logic [31:0] alu, npc;
    logic        e_valid, e_regwen;
    logic [1:0]  e_mtr;
    logic [4:0]  e_wsel;
    logic [31:0] e_alu, e_npc;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ex(input logic e, input logic f, input logic rw, input logic [1:0] mtr,
                        input logic [4:0] ws, input logic [31:0] alu, input logic [31:0] npc,
                        input logic rd, input logic wr, input logic h, input logic [31:0] sd);
    en = e; flush = f;
    epif.ex_RegWEN = rw; epif.ex_MemtoReg = memtoreg_t'(mtr);
    epif.ex_wsel = ws; epif.ex_aluout = alu; epif.ex_npc = npc;
    epif.ex_dRENi = rd; epif.ex_dWENi = wr; epif.ex_halt = h; epif.ex_storedata = sd;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 2'd0, 5'd5,  32'h0000_1234, 32'h0000_0040,
                1'b1, 1'b1, 2'd0, 5'd5,  32'h0000_1234, 32'h0000_0040};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 2'd2, 5'd9,  32'h0000_FFFF, 32'h0000_0099,
                1'b1, 1'b1, 2'd0, 5'd5,  32'h0000_1234, 32'h0000_0040};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 2'd2, 5'd7,  32'h0000_0055, 32'h0000_0077,
                1'b0, 1'b0, 2'd0, 5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 2'd2, 5'd31, 32'h8000_0000, 32'h0000_1000,
                1'b1, 1'b1, 2'd2, 5'd31, 32'h8000_0000, 32'h0000_1000};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 2'd0, 5'd3,  32'hA5A5_A5A5, 32'h0000_0004,
                1'b1, 1'b0, 2'd0, 5'd3,  32'hA5A5_A5A5, 32'h0000_0004};

    // Reset held two cycles with a write-enable present on the inputs
    nRST = 1'b0; dhit = 1'b0; dmemload = '0;
    set_ex(1'b1, 1'b0, 1'b1, 2'd0, 5'd1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 32'h3);
    step(); step();
    chk("rst_valid", 32'(epif.mem_valid), 0);
    chk("rst_regwen", 32'(epif.mem_RegWEN), 0);
    chk("rst_aluout", epif.mem_aluout, 0);
    chk("rst_halt", 32'(epif.mem_halt), 0);
    chk("rst_ren_wen", {30'd0, dmemREN, dmemWEN}, 0);
    chk("rst_stall", 32'(mem_stall), 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    nRST = 1'b1; en = 1'b0;
    step();
    chk("hold_en0_valid", 32'(epif.mem_valid), 0);
    chk("hold_en0_aluout", epif.mem_aluout, 0);

    for (int i = 0; i < 5; i++) begin
      set_ex(vecs[i].en, vecs[i].flush, vecs[i].regwen, vecs[i].mtr, vecs[i].wsel,
             vecs[i].alu, vecs[i].npc, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      chk($sformatf("v%0d_valid", i), 32'(epif.mem_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_regwen", i), 32'(epif.mem_RegWEN), 32'(vecs[i].e_regwen));
      chk($sformatf("v%0d_mtr", i), 32'(epif.mem_MemtoReg), 32'(vecs[i].e_mtr));
      chk($sformatf("v%0d_wsel", i), 32'(epif.mem_wsel), 32'(vecs[i].e_wsel));
      chk($sformatf("v%0d_aluout", i), epif.mem_aluout, vecs[i].e_alu);
      chk($sformatf("v%0d_npc", i), epif.mem_npc, vecs[i].e_npc);
      chk($sformatf("v%0d_req", i), {30'd0, dmemREN, dmemWEN}, 0);
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), 0);
    end

    // Load, dhit on third ACCESS cycle; next ALU op waits on the EX inputs
    set_ex(1'b1, 1'b0, 1'b1, 2'd1, 5'd8, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    set_ex(1'b1, 1'b0, 1'b1, 2'd0, 5'd10, 32'h2222, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int c = 1; c <= 2; c++) begin
      chk($sformatf("ld_c%0d_ren", c), 32'(dmemREN), 1);
      chk($sformatf("ld_c%0d_addr", c), dmemaddr, 32'h100);
      chk($sformatf("ld_c%0d_stall", c), 32'(mem_stall), 1);
      chk($sformatf("ld_c%0d_wsel", c), 32'(epif.mem_wsel), 8);
      step();
    end
    dhit = 1'b1; dmemload = 32'hDEAD_BEEF;
    #1;
    chk("ld_c3_ren", 32'(dmemREN), 1);
    chk("ld_c3_addr", dmemaddr, 32'h100);
    chk("ld_c3_stall", 32'(mem_stall), 0);
    step();
    dhit = 1'b0;
    #1;
    chk("ld_loaddata", epif.mem_loaddata, 32'hDEAD_BEEF);
    chk("ld_stall_cycles", stall_cycles, 2);
    chk("ld_ren_after", 32'(dmemREN), 0);
    chk("ld_next_wsel", 32'(epif.mem_wsel), 10);
    chk("ld_next_aluout", epif.mem_aluout, 32'h2222);

    // Zero-wait store
    set_ex(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_CAFE);
    step();
    set_ex(1'b1, 1'b0, 1'b1, 2'd0, 5'd11, 32'h3333, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    dhit = 1'b1;
    #1;
    chk("st_wen", 32'(dmemWEN), 1);
    chk("st_ren", 32'(dmemREN), 0);
    chk("st_store", dmemstore, 32'h0000_CAFE);
    chk("st_addr", dmemaddr, 32'h200);
    chk("st_stall", 32'(mem_stall), 0);
    step();
    dhit = 1'b0;
    #1;
    chk("st_wen_after", 32'(dmemWEN), 0);
    chk("st_next_aluout", epif.mem_aluout, 32'h3333);
    chk("st_next_wsel", 32'(epif.mem_wsel), 11);
    chk("st_stall_cycles", stall_cycles, 2);

    // Flush raised during a pending load is held off until dhit
    set_ex(1'b1, 1'b0, 1'b1, 2'd1, 5'd12, 32'h300, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    set_ex(1'b1, 1'b1, 1'b1, 2'd0, 5'd13, 32'h4444, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("fl_stall", 32'(mem_stall), 1);
    step();
    chk("fl_hold_valid", 32'(epif.mem_valid), 1);
    chk("fl_hold_wsel", 32'(epif.mem_wsel), 12);
    chk("fl_hold_aluout", epif.mem_aluout, 32'h300);
    dhit = 1'b1; dmemload = 32'h1234_5678;
    step();
    dhit = 1'b0; flush = 1'b0;
    #1;
    chk("fl_bubble_valid", 32'(epif.mem_valid), 0);
    chk("fl_bubble_regwen", 32'(epif.mem_RegWEN), 0);
    chk("fl_bubble_aluout", epif.mem_aluout, 0);
    chk("fl_loaddata", epif.mem_loaddata, 32'h1234_5678);
    chk("fl_ren_after", 32'(dmemREN), 0);
    chk("fl_stall_cycles", stall_cycles, 3);

    // Reset in the middle of an access drops the request without dhit
    set_ex(1'b1, 1'b0, 1'b1, 2'd1, 5'd14, 32'h500, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("mr_ren", 32'(dmemREN), 1);
    nRST = 1'b0;
    step();
    chk("mr_ren_dropped", 32'(dmemREN), 0);
    chk("mr_stall", 32'(mem_stall), 0);
    chk("mr_stall_cycles", stall_cycles, 0);
    nRST = 1'b1;

    // Halt freezes every output until reset
    set_ex(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 32'h400, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    step();
    chk("h_halt", 32'(epif.mem_halt), 1);
    chk("h_valid", 32'(epif.mem_valid), 1);
    chk("h_aluout", epif.mem_aluout, 32'h400);
    for (int i = 0; i < 10; i++) begin
      set_ex(1'b1, 1'b0, 1'b1, 2'd2, 5'(i + 1), 32'h9000 + 32'(i), 32'h8, i == 3, 1'b0, 1'b0, 32'h0);
      step();
      chk($sformatf("h%0d_halt", i), 32'(epif.mem_halt), 1);
      chk($sformatf("h%0d_aluout", i), epif.mem_aluout, 32'h400);
      chk($sformatf("h%0d_wsel", i), 32'(epif.mem_wsel), 0);
      chk($sformatf("h%0d_req", i), {30'd0, dmemREN, dmemWEN}, 0);
    end
    nRST = 1'b0;
    step();
    chk("h_rst_halt", 32'(epif.mem_halt), 0);
    chk("h_rst_valid", 32'(epif.mem_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
